// File: rtl/inst_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB per instruction
// and raises a sticky fault if a memory handshake exceeds WAIT_MAX request cycles.
module inst_sequencer #(
    parameter int N        = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] opcode_i,
    input  logic         imem_ack_i,
    input  logic         dmem_ack_i,
    input  logic         br_taken_i,
    output logic         imem_req_o,
    output logic         ir_we_o,
    output logic         dmem_req_o,
    output logic         dmem_we_o,
    output logic         rf_we_o,
    output logic [1:0]   wb_sel_o,
    output logic         alu_src_imm_o,
    output logic         pc_we_o,
    output logic [1:0]   pc_sel_o,
    output logic [2:0]   fmt_o,
    output logic [2:0]   state_o,
    output logic         instr_done_o,
    output logic         illegal_o,
    output logic         fault_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        F_R   = 3'd0,
        F_I   = 3'd1,
        F_S   = 3'd2,
        F_B   = 3'd3,
        F_J   = 3'd4,
        F_NOP = 3'd5
    } fmt_e;

    localparam logic [N-1:0] OP_R    = N'(5'b01100);
    localparam logic [N-1:0] OP_IALU = N'(5'b00100);
    localparam logic [N-1:0] OP_LOAD = N'(5'b00000);
    localparam logic [N-1:0] OP_JALR = N'(5'b11001);
    localparam logic [N-1:0] OP_S    = N'(5'b01000);
    localparam logic [N-1:0] OP_B    = N'(5'b11000);
    localparam logic [N-1:0] OP_J    = N'(5'b11011);
    localparam logic [7:0]   WAIT_LAST = 8'(WAIT_MAX - 1);

    function automatic fmt_e classify(input logic [N-1:0] op);
        case (op)
            OP_R:                      return F_R;
            OP_IALU, OP_LOAD, OP_JALR: return F_I;
            OP_S:                      return F_S;
            OP_B:                      return F_B;
            OP_J:                      return F_J;
            default:                   return F_NOP;
        endcase
    endfunction

    state_e       state_q, state_d;
    fmt_e         fmt_q, fmt_d;
    logic [N-1:0] op_q, op_d;
    logic [7:0]   wait_q, wait_d;
    logic         fault_q, fault_d;
    logic         final_c;
    logic         is_load, is_jalr;

    // Class I covers three behaviours; the latched opcode tells them apart.
    assign is_load = (fmt_q == F_I) && (op_q == OP_LOAD);
    assign is_jalr = (fmt_q == F_I) && (op_q == OP_JALR);

    always_comb begin
        state_d       = state_q;
        fmt_d         = fmt_q;
        op_d          = op_q;
        wait_d        = wait_q;
        fault_d       = fault_q;
        final_c       = 1'b0;
        imem_req_o    = 1'b0;
        ir_we_o       = 1'b0;
        dmem_req_o    = 1'b0;
        dmem_we_o     = 1'b0;
        rf_we_o       = 1'b0;
        wb_sel_o      = 2'd0;
        alu_src_imm_o = 1'b0;
        pc_sel_o      = 2'd0;
        illegal_o     = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                fmt_d   = classify(opcode_i);
                op_d    = opcode_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_src_imm_o = (fmt_q == F_I) || (fmt_q == F_S);
                case (fmt_q)
                    F_R, F_J: state_d = S_WB;
                    F_I: begin
                        state_d = is_load ? S_MEM : S_WB;
                        wait_d  = 8'd0;
                    end
                    F_S: begin
                        state_d = S_MEM;
                        wait_d  = 8'd0;
                    end
                    F_B: begin
                        final_c  = 1'b1;
                        pc_sel_o = br_taken_i ? 2'd1 : 2'd0;
                    end
                    default: begin
                        final_c   = 1'b1;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (fmt_q == F_S);
                if (dmem_ack_i) begin
                    if (fmt_q == F_S) final_c = 1'b1;
                    else              state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rf_we_o  = 1'b1;
                final_c  = 1'b1;
                wb_sel_o = is_load ? 2'd1 : ((is_jalr || fmt_q == F_J) ? 2'd2 : 2'd0);
                pc_sel_o = is_jalr ? 2'd2 : ((fmt_q == F_J) ? 2'd1 : 2'd0);
            end
            default: ;
        endcase

        if (final_c) begin
            state_d = S_FETCH;
            wait_d  = 8'd0;
        end

        // Reset forces every strobe quiet in the same cycle it is asserted.
        if (rst) begin
            final_c       = 1'b0;
            imem_req_o    = 1'b0;
            ir_we_o       = 1'b0;
            dmem_req_o    = 1'b0;
            dmem_we_o     = 1'b0;
            rf_we_o       = 1'b0;
            wb_sel_o      = 2'd0;
            alu_src_imm_o = 1'b0;
            pc_sel_o      = 2'd0;
            illegal_o     = 1'b0;
        end
    end

    assign pc_we_o      = final_c;
    assign instr_done_o = final_c;
    assign state_o      = state_q;
    assign fmt_o        = fmt_q;
    assign fault_o      = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            fmt_q   <= F_NOP;
            op_q    <= '0;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: scoreboard of per-instruction expectations,
// plus handshake timeout and reset-recovery steps.
module tb_inst_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic       imem_ack, dmem_ack, br_taken;
    logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, alu_src_imm, pc_we;
    logic [1:0] wb_sel, pc_sel;
    logic [2:0] fmt, state;
    logic       instr_done, illegal, fault;

    inst_sequencer #(.N(5), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .opcode_i(opcode), .imem_ack_i(imem_ack),
        .dmem_ack_i(dmem_ack), .br_taken_i(br_taken), .imem_req_o(imem_req),
        .ir_we_o(ir_we), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .rf_we_o(rf_we), .wb_sel_o(wb_sel), .alu_src_imm_o(alu_src_imm),
        .pc_we_o(pc_we), .pc_sel_o(pc_sel), .fmt_o(fmt), .state_o(state),
        .instr_done_o(instr_done), .illegal_o(illegal), .fault_o(fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string trace;
        int    pc_sel, wb_sel, rf, ill, dm, dwe, fmt, imm;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tr, input int ps, input int ws, input int rf,
                            input int ill, input int dm, input int dwe, input int f,
                            input int imm);
        exp_t e;
        e.trace = tr; e.pc_sel = ps; e.wb_sel = ws; e.rf = rf; e.ill = ill;
        e.dm = dm; e.dwe = dwe; e.fmt = f; e.imm = imm;
        sbq.push_back(e);
    endtask

    task automatic step(input logic ia, input logic da);
        @(posedge clk);
        #1 imem_ack = ia; dmem_ack = da;
        #1;
    endtask

    // Drives one instruction, acking fetch after iw waits and data after dw waits.
    task automatic run_instr(input string tag, input logic [4:0] op, input int iw,
                             input int dw, input logic br, input logic noise);
        exp_t o, e;
        int   fc = 0, mc = 0, cyc = 0, pcwe = 0;
        bit   done = 0;
        o.trace = ""; o.pc_sel = 0; o.wb_sel = 0; o.rf = 0; o.ill = 0;
        o.dm = 0; o.dwe = 0; o.fmt = -1; o.imm = 0;
        while (!done && cyc < 64) begin
            @(posedge clk);
            #1;
            opcode   = op;
            br_taken = br;
            imem_ack = (state == 3'd0) ? (fc == iw) : noise;
            dmem_ack = (state == 3'd3) ? (mc == dw) : noise;
            #1;
            o.trace = {o.trace, $sformatf("%0d", state)};
            if (state == 3'd0) fc++;
            if (state == 3'd3) mc++;
            if (state == 3'd2) o.fmt = fmt;
            o.rf   += rf_we;
            o.ill  += illegal;
            o.dm   += dmem_req;
            o.imm  += alu_src_imm;
            pcwe   += pc_we;
            if (dmem_req && dmem_we) o.dwe = 1;
            if (instr_done) begin
                done     = 1;
                o.pc_sel = pc_sel;
                o.wb_sel = wb_sel;
            end
            cyc++;
        end
        chk({tag, " done"}, done, 1);
        if (sbq.size() == 0) begin
            chk({tag, " sb_empty"}, 0, 1);
        end else begin
            e = sbq.pop_front();
            total++;
            assert (o.trace == e.trace) else begin
                bad++;
                $error("FAIL %s trace observed=%s expected=%s", tag, o.trace, e.trace);
            end
            chk({tag, " pc_sel"}, o.pc_sel, e.pc_sel);
            chk({tag, " wb_sel"}, o.wb_sel, e.wb_sel);
            chk({tag, " rf_we"}, o.rf, e.rf);
            chk({tag, " illegal"}, o.ill, e.ill);
            chk({tag, " dmem_req"}, o.dm, e.dm);
            chk({tag, " dmem_we"}, o.dwe, e.dwe);
            chk({tag, " fmt"}, o.fmt, e.fmt);
            chk({tag, " alu_imm"}, o.imm, e.imm);
            chk({tag, " pc_we"}, pcwe, 1);
        end
    endtask

    initial begin
        string z15;
        rst = 1'b1; opcode = 5'd0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;

        // Reset state and quiet outputs while rst is held
        step(0, 0);
        step(1, 1);
        chk("rst imem_req", imem_req, 0);
        chk("rst ir_we", ir_we, 0);
        chk("rst dmem_req", dmem_req, 0);
        chk("rst pc_we", pc_we, 0);
        chk("rst state", state, 0);
        chk("rst fmt", fmt, 5);
        chk("rst fault", fault, 0);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        rst = 1'b0;
        #1 chk("post-rst imem_req", imem_req, 1);

        push_exp("0124", 0, 0, 1, 0, 0, 0, 0, 0);
        run_instr("R", 5'b01100, 0, 0, 0, 0);
        push_exp("01233334", 0, 1, 1, 0, 4, 0, 1, 1);
        run_instr("LOAD", 5'b00000, 0, 3, 0, 0);
        push_exp("0123", 0, 0, 0, 0, 1, 1, 2, 1);
        run_instr("STORE", 5'b01000, 0, 0, 0, 0);
        push_exp("012", 1, 0, 0, 0, 0, 0, 3, 0);
        run_instr("BR_T", 5'b11000, 0, 0, 1, 0);
        push_exp("012", 0, 0, 0, 0, 0, 0, 3, 0);
        run_instr("BR_NT", 5'b11000, 0, 0, 0, 0);
        push_exp("012", 0, 0, 0, 1, 0, 0, 5, 0);
        run_instr("NOP", 5'b11111, 0, 0, 0, 0);
        push_exp("0124", 2, 2, 1, 0, 0, 0, 1, 1);
        run_instr("JALR", 5'b11001, 0, 0, 0, 0);
        push_exp("0124", 1, 2, 1, 0, 0, 0, 4, 0);
        run_instr("J", 5'b11011, 0, 0, 0, 0);
        push_exp("000124", 0, 0, 1, 0, 0, 0, 1, 1);
        run_instr("IALU_NOISE", 5'b00100, 2, 0, 0, 1);
        push_exp("012333", 0, 0, 0, 0, 3, 1, 2, 1);
        run_instr("STORE_NOISE", 5'b01000, 0, 2, 0, 1);
        z15 = "";
        repeat (15) z15 = {z15, "0"};
        push_exp({z15, "124"}, 0, 0, 1, 0, 0, 0, 0, 0);
        run_instr("R_WAIT15", 5'b01100, 14, 0, 0, 0);

        // Fetch never acknowledged: 15 request cycles, then FAULT
        opcode = 5'b01100;
        for (int i = 0; i < 15; i++) step(0, 0);
        chk("to cyc15 state", state, 0);
        chk("to cyc15 imem_req", imem_req, 1);
        step(0, 0);
        chk("to state", state, 5);
        chk("to fault", fault, 1);
        chk("to imem_req", imem_req, 0);
        step(1, 1);
        chk("fault sticky state", state, 5);
        chk("fault ir_we", ir_we, 0);
        chk("fault pc_we", pc_we, 0);
        @(posedge clk);
        #1 rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("fault rst state", state, 0);
        chk("fault rst fault", fault, 0);
        chk("fault rst fmt", fmt, 5);
        rst = 1'b0;

        // Reset in the middle of a store's data wait
        opcode = 5'b01000;
        step(1, 0);
        chk("st fetch ir_we", ir_we, 1);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        chk("st mem state", state, 3);
        chk("st mem dmem_req", dmem_req, 1);
        chk("st mem dmem_we", dmem_we, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("st rst dmem_req", dmem_req, 0);
        chk("st rst imem_req", imem_req, 0);
        @(posedge clk);
        #1;
        chk("st rst state", state, 0);
        chk("st rst fault", fault, 0);
        rst = 1'b0;
        #1 chk("st rst imem_req", imem_req, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter N, default 5, SHALL set the opcode field width (instruction bits [6:2]).
REQ-002 Parameter WAIT_MAX, default 15, SHALL set the maximum number of request cycles allowed without an acknowledge; legal range 1..255.
REQ-003 The clock port SHALL be: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The reset port SHALL be: rst  input  1  synchronous, active-high reset.
REQ-005 opcode  input  N  inst[6:2] of the instruction register contents.
REQ-006 imem_ack  input  1  instruction-memory acknowledge; data valid this cycle.
REQ-007 dmem_ack  input  1  data-memory acknowledge; access complete this cycle.
REQ-008 br_taken  input  1  branch comparison result, valid in EXEC.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 ir_we  output  1  instruction-register load strobe.
REQ-011 dmem_req  output  1  data access request; dmem_we  output  1  store (1) or load (0).
REQ-012 rf_we  output  1  register-file write strobe; wb_sel  output  2  0=ALU, 1=memory, 2=PC+4.
REQ-013 alu_src_imm  output  1  ALU operand B is the immediate.
REQ-014 pc_we  output  1  PC update strobe; pc_sel  output  2  0=PC+4, 1=PC+imm, 2=ALU result.
REQ-015 fmt  output  3  registered format class: R=0, I=1, S=2, B=3, J=4, NOP=5.
REQ-016 state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
REQ-017 instr_done  output  1  one-cycle pulse in the last cycle of every instruction; illegal  output  1  one-cycle pulse in EXEC for a NOP-class opcode; fault  output  1  sticky handshake-timeout flag.

Function
REQ-018 Class decode SHALL map opcode 01100->R; 00100, 00000, 11001->I; 01000->S; 11000->B; 11011->J; all other values->NOP.
REQ-019 FETCH SHALL hold imem_req=1 until imem_ack=1; ir_we=1 in the ack cycle only; the next state is DECODE.
REQ-020 DECODE SHALL last one cycle, load fmt from the opcode, and go to EXEC.
REQ-021 alu_src_imm SHALL be 1 in EXEC for classes I and S, and 0 otherwise.
REQ-022 Class R / I-ALU (00100): EXEC -> WB with rf_we=1, wb_sel=0, pc_sel=0.
REQ-023 Load (00000): EXEC -> MEM (dmem_req=1, dmem_we=0 until dmem_ack) -> WB with rf_we=1, wb_sel=1, pc_sel=0.
REQ-024 Store (S): EXEC -> MEM (dmem_req=1, dmem_we=1); the dmem_ack cycle is final, with pc_sel=0.
REQ-025 JALR (11001): EXEC -> WB with rf_we=1, wb_sel=2, pc_sel=2.
REQ-026 J: EXEC -> WB with rf_we=1, wb_sel=2, pc_sel=1.
REQ-027 B: EXEC is final, with pc_sel=1 if br_taken=1, else pc_sel=0.
REQ-028 NOP class: EXEC is final, with pc_sel=0, illegal=1, and no rf or dmem activity.
REQ-029 pc_we and instr_done SHALL be 1 only in the final cycle; the next state after the final cycle is FETCH.
REQ-030 With zero-wait acknowledges, latency SHALL be 4 cycles for R/I-ALU/JALR/J, 5 for loads, 4 for stores, and 3 for B/NOP.
REQ-031 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each request cycle without an acknowledge.
REQ-032 An acknowledge in request cycle WAIT_MAX SHALL be accepted; if request cycle WAIT_MAX ends without an acknowledge, the next state SHALL be FAULT.
REQ-033 In FAULT: fault=1, all request/strobe outputs 0, and the state stays FAULT until rst.
REQ-034 Acknowledges arriving outside FETCH (imem_ack) or outside MEM (dmem_ack) SHALL be ignored.
REQ-035 All strobe/request outputs SHALL be decoded from state, fmt and the inputs only; no output depends on a previous cycle's acknowledge.

Reset
REQ-036 A clock edge with rst=1 SHALL set state=FETCH, fmt=NOP, wait counter=0 and fault=0, regardless of the current state, including mid-MEM and FAULT.
REQ-037 While rst=1, imem_req, dmem_req, ir_we, rf_we, pc_we, instr_done and illegal SHALL be 0; alu_src_imm, wb_sel and pc_sel SHALL be 0.
REQ-038 The first cycle after rst falls SHALL drive imem_req=1.

Verification
REQ-039 R op (opcode 01100), immediate acks -> states 0,1,2,4; rf_we=1 and wb_sel=0 in cycle 4; pc_we/instr_done pulse once.
REQ-040 Load (00000), dmem_ack after 3 wait cycles -> MEM lasts 4 cycles; dmem_we=0; WB has wb_sel=1; total latency 8 cycles.
REQ-041 Branch (11000) with br_taken=1, then with br_taken=0 -> final EXEC drives pc_sel=1, then pc_sel=0; rf_we stays 0.
REQ-042 Opcode 11111 -> fmt=5, illegal pulses once in EXEC, instr_done after 3 cycles, no dmem_req.
REQ-043 WAIT_MAX=15: imem_ack in fetch cycle 15 -> DECODE next; imem_ack never given -> FAULT after cycle 15, fault=1, imem_req=0.
REQ-044 rst asserted during a store's MEM wait -> dmem_req=0 while rst=1; state=FETCH and fault=0 after the edge; imem_req=1 the cycle rst falls.
